ask_tx_scheduler: RTL and testbench

Frame sequencer that feeds the ASK modulator's data input and sample index.
- Accepts data words from one requester over a valid/ready handshake.
- Wraps each word in a preamble and a guard interval.
- Holds each bit on din_o for exactly one sine period, SAMPLES_PER_BIT samples.
- Drives phase_o as the sine-table index, so bit edges align with sine-period edges.

---
 rtl/ask_pkg.sv | 27 ++
 rtl/ask_bit_timer.sv | 38 +++
 rtl/ask_tx_scheduler.sv | 166 ++++++++++++++++
 tb/tb_ask_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ask_pkg.sv
// Shared types and constants for the ASK transmit scheduler.
package ask_pkg;

    // Width of the sine-table index driven to the modulator.
    localparam int SINE_IDX_W = 6;

    // Default frame geometry.
    localparam int ASK_SAMPLES_PER_BIT = 64;
    localparam int ASK_DATA_W          = 8;
    localparam int ASK_PRE_LEN         = 4;
    localparam int ASK_GUARD_BITS      = 1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GUARD
    } ask_tx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ask_bit_timer.sv
// Sine-period timer: phase counter that wraps every SAMPLES_PER_BIT cycles
// and flags the last sample of each bit.
module ask_bit_timer
    import ask_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = ASK_SAMPLES_PER_BIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  clear,
    output logic [SINE_IDX_W-1:0] phase,
    output logic                  bit_tick
);

    localparam logic [SINE_IDX_W-1:0] PH_LAST = SINE_IDX_W'(SAMPLES_PER_BIT - 1);

    logic [SINE_IDX_W-1:0] r_phase;

    // Phase counter: cleared on abort, advances while a frame runs, wraps at the bit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (run) begin
            if (r_phase == PH_LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    assign phase    = r_phase;
    assign bit_tick = run && (r_phase == PH_LAST);

endmodule

// File: rtl/ask_tx_scheduler.sv
// ASK transmit frame sequencer: preamble, MSB-first payload, guard interval,
// with din_o held for one full sine period per bit and phase_o as the table index.
// Optional build macro ASK_TX_PARITY_EN adds an even-parity bit after the payload.
//
// state | meaning
// IDLE  | waiting for a word, tx_ready high, outputs at rest
// PRE   | alternating 1,0,... preamble bits
// DATA  | payload bits, MSB first, from the shift register
// PAR   | even parity over the payload (ASK_TX_PARITY_EN builds only)
// GUARD | zero bits closing the frame; last sample pulses done
module ask_tx_scheduler
    import ask_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = ASK_SAMPLES_PER_BIT,
    parameter int DATA_W          = ASK_DATA_W,
    parameter int PRE_LEN         = ASK_PRE_LEN,
    parameter int GUARD_BITS      = ASK_GUARD_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    input  logic [DATA_W-1:0]     tx_data,
    output logic                  tx_ready,
    input  logic                  abort,
    output logic                  din_o,
    output logic [SINE_IDX_W-1:0] phase_o,
    output logic                  mod_en,
    output logic                  done
);

    localparam int MAX_BITS = max3(PRE_LEN, DATA_W, GUARD_BITS);
    localparam int CNT_W    = ($clog2(MAX_BITS) < 1) ? 1 : $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0]      PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0]      DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_BITS - 1);
    localparam logic [SINE_IDX_W-1:0] PH_PENULT  = SINE_IDX_W'(SAMPLES_PER_BIT - 2);

    ask_tx_state_t         r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_shreg;
    logic                  r_din;
    logic                  r_mod_en;
    logic                  r_done;
`ifdef ASK_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic [SINE_IDX_W-1:0] w_phase;
    logic                  w_tick;
    logic                  w_run;
    logic                  w_guard_last;
    logic                  w_accept;

    assign w_run = (r_state != IDLE);

    ask_bit_timer #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_run),
        .clear   (abort),
        .phase   (w_phase),
        .bit_tick(w_tick)
    );

    // Ready in IDLE and on the final guard sample so frames can run back to back;
    // abort always wins over a new word.
    assign w_guard_last = (r_state == GUARD) && (r_cnt == GUARD_LAST);
    assign tx_ready     = !abort && ((r_state == IDLE) || (w_guard_last && w_tick));
    assign w_accept     = tx_valid && tx_ready;

    // Frame sequencer: state, bit counter, payload shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_din    <= 1'b0;
            r_mod_en <= 1'b0;
            r_done   <= 1'b0;
`ifdef ASK_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            // done marks the last guard sample, so it is raised one sample early.
            r_done <= !abort && w_guard_last && (w_phase == PH_PENULT);

            if (abort && (r_state != IDLE)) begin
                r_state  <= IDLE;
                r_cnt    <= '0;
                r_din    <= 1'b0;
                r_mod_en <= 1'b0;
            end else if (w_accept) begin
                r_state  <= PRE;
                r_cnt    <= '0;
                r_shreg  <= tx_data;
                r_din    <= 1'b1;
                r_mod_en <= 1'b1;
`ifdef ASK_TX_PARITY_EN
                r_parity <= ^tx_data;
`endif
            end else if (w_tick) begin
                case (r_state)
                    PRE: begin
                        if (r_cnt == PRE_LAST) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_din   <= r_shreg[DATA_W-1];
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            // Next preamble index is odd when the current one is even.
                            r_din <= r_cnt[0];
                        end
                    end
                    DATA: begin
                        if (r_cnt == DATA_LAST) begin
                            r_cnt <= '0;
`ifdef ASK_TX_PARITY_EN
                            r_state <= PAR;
                            r_din   <= r_parity;
`else
                            r_state <= GUARD;
                            r_din   <= 1'b0;
`endif
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
                            r_din   <= r_shreg[DATA_W-2];
                        end
                    end
`ifdef ASK_TX_PARITY_EN
                    PAR: begin
                        r_state <= GUARD;
                        r_cnt   <= '0;
                        r_din   <= 1'b0;
                    end
`endif
                    GUARD: begin
                        r_din <= 1'b0;
                        if (r_cnt == GUARD_LAST) begin
                            r_state  <= IDLE;
                            r_cnt    <= '0;
                            r_mod_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_din    <= 1'b0;
                        r_mod_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign din_o   = r_din;
    assign phase_o = w_phase;
    assign mod_en  = r_mod_en;
    assign done    = r_done;

endmodule

// File: tb/tb_ask_tx_scheduler.sv
// Scoreboard bench for ask_tx_scheduler: a frame-level model pushes expected
// bits and completion times; a monitor pops and compares as the DUT emits them.
module tb_ask_tx_scheduler;

    localparam int SPB   = 64;
    localparam int DW    = 8;
    localparam int PRE   = 4;
    localparam int GUARD = 1;
`ifdef ASK_TX_PARITY_EN
    localparam int NPAR  = 1;
`else
    localparam int NPAR  = 0;
`endif
    localparam int NBITS = PRE + DW + NPAR + GUARD;
    localparam int FRAME = NBITS * SPB;

    logic          clk;
    logic          rst_n;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          abort;
    logic          din_o;
    logic [5:0]    phase_o;
    logic          mod_en;
    logic          done;

    ask_tx_scheduler #(
        .SAMPLES_PER_BIT(SPB),
        .DATA_W         (DW),
        .PRE_LEN        (PRE),
        .GUARD_BITS     (GUARD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .abort   (abort),
        .din_o   (din_o),
        .phase_o (phase_o),
        .mod_en  (mod_en),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state: the window of edges where a frame is on the air, and the
    // edge on which the scheduler is next able to take a word.
    int en_from  = 0;
    int en_to    = -1;
    int busy_to  = -1;
    int last_acc = 0;
    bit q_bits[$];
    int q_done[$];
    bit cur_bit  = 1'b0;

    function automatic void chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_frame(input logic [DW-1:0] d, input int acc);
        for (int i = 0; i < PRE; i++) q_bits.push_back((i % 2) == 0);
        for (int i = 0; i < DW; i++) q_bits.push_back(d[DW-1-i]);
        if (NPAR == 1) q_bits.push_back(^d);
        for (int i = 0; i < GUARD; i++) q_bits.push_back(1'b0);
        q_done.push_back(acc + FRAME - 1);
    endfunction

    // Monitor: sample #1 after each rising edge and compare against the model.
    initial begin
        forever begin
            bit exp_en;
            int exp_ph;
            bit exp_done;
            @(posedge clk);
            cyc++;
            #1;
            exp_en = (cyc >= en_from) && (cyc <= en_to);
            exp_ph = exp_en ? ((cyc - en_from) % SPB) : 0;
            chk(mod_en == exp_en, "mod_en", mod_en, exp_en);
            chk(int'(phase_o) == exp_ph, "phase_o", phase_o, exp_ph);
            if (!exp_en) begin
                chk(din_o == 1'b0, "din_idle", din_o, 0);
            end else if (exp_ph == 0) begin
                chk(q_bits.size() > 0, "bit_queue", q_bits.size(), 1);
                if (q_bits.size() > 0) cur_bit = q_bits.pop_front();
                chk(din_o == cur_bit, "din_bit_start", din_o, cur_bit);
            end else begin
                chk(din_o == cur_bit, "din_bit_hold", din_o, cur_bit);
            end
            exp_done = (q_done.size() > 0) && (q_done[0] == cyc);
            if (exp_done) void'(q_done.pop_front());
            chk(done == exp_done, "done", done, exp_done);
        end
    end

    // One cycle of stimulus, entered and left at a falling edge.
    task automatic drive(input bit v, input logic [DW-1:0] d, input bit ab, output bit acc);
        bit exp_ready;
        tx_valid = v;
        tx_data  = d;
        abort    = ab;
        acc      = 1'b0;
        #1;
        exp_ready = !ab && (cyc >= busy_to);
        chk(tx_ready == exp_ready, "tx_ready", tx_ready, exp_ready);
        if (ab && (cyc < busy_to)) begin
            q_bits.delete();
            q_done.delete();
            en_to   = cyc;
            busy_to = cyc + 1;
        end else if (v && exp_ready) begin
            acc      = 1'b1;
            last_acc = cyc + 1;
            push_frame(d, last_acc);
            en_from  = last_acc;
            en_to    = last_acc + FRAME - 1;
            busy_to  = last_acc + FRAME - 1;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < FRAME + 16) begin
            drive(1'b1, d, 1'b0, a);
            n++;
        end
        chk(a, "accept_timeout", a, 1);
    endtask

    task automatic run_to(input int edge_no);
        bit a;
        int n;
        n = 0;
        while (cyc < edge_no && n < 2 * FRAME) begin
            drive(1'b0, DW'($urandom), 1'b0, a);
            n++;
        end
        chk(cyc >= edge_no, "run_timeout", cyc, edge_no);
    endtask

    task automatic wait_idle();
        bit a;
        run_to(busy_to);
        drive(1'b0, DW'($urandom), 1'b0, a);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk(din_o == 1'b0, "rst_din", din_o, 0);
        chk(phase_o == 6'd0, "rst_phase", phase_o, 0);
        chk(mod_en == 1'b0, "rst_mod_en", mod_en, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(tx_ready == 1'b1, "rst_ready", tx_ready, 1);
        q_bits.delete();
        q_done.delete();
        en_to   = cyc;
        busy_to = cyc;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit a;
        int first_acc;
        rst_n    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        abort    = 1'b0;
        #1 rst_n = 1'b0;

        // Reset held with a pending word.
        repeat (2) @(negedge clk);
        #1;
        chk(din_o == 1'b0, "rst_din", din_o, 0);
        chk(phase_o == 6'd0, "rst_phase", phase_o, 0);
        chk(mod_en == 1'b0, "rst_mod_en", mod_en, 0);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(tx_ready == 1'b1, "rst_ready", tx_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // First word is taken on the first edge after release.
        drive(1'b1, 8'hA5, 1'b0, a);
        chk(a, "first_accept", a, 1);
        wait_idle();

        // Back to back with valid held high.
        send(8'hFF);
        first_acc = last_acc;
        send(8'h00);
        chk(last_acc == first_acc + FRAME, "b2b_gap", last_acc - first_acc, FRAME);
        wait_idle();

        // Abort at DATA bit 3, phase 17, then abort together with a word in IDLE.
        send(8'h3C);
        run_to(last_acc + (PRE + 3) * SPB + 17);
        drive(1'b0, 8'h00, 1'b1, a);
        drive(1'b1, 8'h55, 1'b1, a);
        chk(!a, "abort_blocks_accept", a, 0);
        drive(1'b0, 8'h00, 1'b0, a);

        // Asynchronous reset mid-DATA, then a full frame.
        send(8'hC3);
        run_to(last_acc + (PRE + 2) * SPB + 5);
        pulse_reset();
        send(8'h96);
        wait_idle();

        // Parity cases (plain frames when parity is not built in).
        send(8'h07);
        wait_idle();
        send(8'h03);
        wait_idle();

        // Randomised words, gaps and aborts.
        for (int f = 0; f < 12; f++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive(1'b0, DW'($urandom), 1'b0, a);
            send(DW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                run_to(last_acc + $urandom_range(1, FRAME - 3));
                drive(1'b0, DW'($urandom), 1'b1, a);
            end
        end
        wait_idle();
        repeat (3) drive(1'b0, DW'($urandom), 1'b0, a);

        chk(q_bits.size() == 0, "bits_left", q_bits.size(), 0);
        chk(q_done.size() == 0, "done_left", q_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
